mem_access_ctrl: RTL

- Memory-stage controller between the EX/MEM pipeline register and the MEM/WB register (mem_wb).
- Performs data-memory loads and stores over a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Presents the stage results that mem_wb captures: lwsrc, write address, reg-write, ALU/mov result and aligned load data.

---
 rtl/mem_access_ctrl_if.sv | 14 +
 rtl/mem_access_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: data-memory req/ack bus between the memory-stage controller and data memory
// master (controller): drives dm_req, dm_we, dm_addr, dm_wdata, dm_ben; samples dm_ack, dm_rdata
// slave (memory): the reverse
interface mem_access_ctrl_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_ben;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  modport master (output dm_req, dm_we, dm_addr, dm_wdata, dm_ben, input dm_ack, dm_rdata);
  modport slave (input dm_req, dm_we, dm_addr, dm_wdata, dm_ben, output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage controller issuing loads/stores over a req/ack bus and feeding mem_wb
// clk/rst: clock, async active-low reset; ex_*: EX/MEM slot; dm: data-memory bus (master)
// stall_o: holds upstream pipeline; mem_*: results for mem_wb; bus_err_o: sticky timeout; misalign_o: drop pulse
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC = 16,
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_load_signed,
  input  logic        ex_lwsrc,
  input  logic [4:0]  ex_write_addr,
  input  logic        ex_reg_write,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  mem_access_ctrl_if.master dm,
  output logic        stall_o,
  output logic        mem_lwsrc,
  output logic [4:0]  mem_write_addr_o,
  output logic        mem_reg_write,
  output logic [31:0] mem_movsrc_result,
  output logic [31:0] mem_dm_out,
  output logic        bus_err_o,
  output logic        misalign_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q;
  logic [31:0] addr_q, daddr_q, wdata_q, ldata_q;
  logic [1:0] size_q;
  logic [3:0] ben_q;
  logic [4:0] wa_q;
  logic [TO_W-1:0] to_q;
  logic sign_q, lwsrc_q, rw_q, req_q, we_q, bus_err_q, misalign_q;
  logic memop, mis, pass, resp;
  logic [3:0] ben_d;
  logic [31:0] wdata_d, load_d;
  logic [7:0] byte_l;
  logic [15:0] half_l;
  assign memop = ex_valid & (ex_mem_read | ex_mem_write);
  assign mis = (ex_mem_size == 2'b01 & ex_alu_result[0]) | (ex_mem_size[1] & |ex_alu_result[1:0]);
  assign ben_d = ex_mem_size == 2'b00 ? 4'b0001 << ex_alu_result[1:0] :
                 ex_mem_size == 2'b01 ? (ex_alu_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_d = ex_mem_size == 2'b00 ? {4{ex_store_data[7:0]}} :
                   ex_mem_size == 2'b01 ? {2{ex_store_data[15:0]}} : ex_store_data;
  assign byte_l = dm.dm_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_l = addr_q[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
  assign load_d = size_q == 2'b00 ? {{24{sign_q & byte_l[7]}}, byte_l} :
                  size_q == 2'b01 ? {{16{sign_q & half_l[15]}}, half_l} : dm.dm_rdata;
  // rst gates the combinational paths so reset silences the stage in the same cycle
  assign pass = rst & state_q == IDLE & ~memop;
  assign resp = state_q == RESP;
  assign stall_o = rst & ((state_q == IDLE & memop) | state_q == ACCESS);
  assign mem_lwsrc = pass ? ex_lwsrc : resp & lwsrc_q;
  assign mem_write_addr_o = pass ? ex_write_addr : resp ? wa_q : 5'd0;
  assign mem_reg_write = pass ? ex_reg_write & ex_valid : resp & rw_q;
  assign mem_movsrc_result = pass ? ex_alu_result : resp ? addr_q : 32'd0;
  assign mem_dm_out = resp ? ldata_q : 32'd0;
  assign bus_err_o = bus_err_q;
  assign misalign_o = misalign_q;
  assign dm.dm_req = req_q;
  assign dm.dm_we = we_q;
  assign dm.dm_addr = daddr_q;
  assign dm.dm_wdata = wdata_q;
  assign dm.dm_ben = ben_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      {addr_q, daddr_q, wdata_q, ldata_q, size_q, ben_q, wa_q, to_q} <= '0;
      {sign_q, lwsrc_q, rw_q, req_q, we_q, bus_err_q, misalign_q} <= '0;
    end else
      case (state_q)
        IDLE: if (memop) begin
          addr_q <= ex_alu_result;
          size_q <= ex_mem_size;
          sign_q <= ex_load_signed;
          lwsrc_q <= ex_lwsrc;
          wa_q <= ex_write_addr;
          rw_q <= ex_reg_write & ~mis;
          ldata_q <= '0;
          to_q <= '0;
          misalign_q <= mis;
          req_q <= ~mis;
          we_q <= ~mis & ~ex_mem_read;
          daddr_q <= {ex_alu_result[31:2], 2'b00};
          wdata_q <= mis ? 32'd0 : wdata_d;
          ben_q <= mis ? 4'd0 : ben_d;
          state_q <= mis ? RESP : ACCESS;
        end
        ACCESS: if (dm.dm_ack || to_q == TO_W'(TIMEOUT_CYC - 1)) begin
          // an ack in the final allowed cycle still completes normally
          ldata_q <= dm.dm_ack ? load_d : 32'd0;
          rw_q <= rw_q & dm.dm_ack;
          bus_err_q <= bus_err_q | ~dm.dm_ack;
          req_q <= 1'b0;
          we_q <= 1'b0;
          ben_q <= 4'd0;
          state_q <= RESP;
        end else
          to_q <= to_q + TO_W'(1);
        default: begin
          misalign_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
endmodule
